// File: rtl/free_index_allocator_pkg.sv
// Shared types for the free index allocator: the selection policy enum.
package free_index_allocator_pkg;

  typedef enum logic {
    ALLOC_FIXED = 1'b0,
    ALLOC_RR    = 1'b1
  } alloc_mode_e;

endpackage

// File: rtl/free_index_allocator_if.sv
// Allocation offer, release ports and status outputs of the free index allocator.
interface free_index_allocator_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_RELEASE = 2
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  logic                                alloc_valid;
  logic [IDX_W-1:0]                    alloc_index;
  logic                                alloc_ready;
  logic [NUM_RELEASE-1:0]              release_valid;
  logic [NUM_RELEASE-1:0][IDX_W-1:0]   release_index;
  logic [NUM_ENTRIES-1:0]              free_bitmap;
  logic [CNT_W-1:0]                    free_count;
  logic                                all_free;
  logic                                double_free_err;

  modport master (
    output alloc_valid, alloc_index, free_bitmap, free_count, all_free, double_free_err,
    input  alloc_ready, release_valid, release_index
  );

  modport slave (
    input  alloc_valid, alloc_index, free_bitmap, free_count, all_free, double_free_err,
    output alloc_ready, release_valid, release_index
  );

endinterface

// File: rtl/free_index_allocator_next_free.sv
// Highest-set-bit finder used to pick the offered free index.
module next_free_index_comb #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_bitmap,
  output logic             o_found,
  output logic [IDX_W-1:0] o_index
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    o_found = |i_bitmap;
    o_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_bitmap[i]) o_index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/free_index_allocator.sv
// Free-list allocator: offers one free index per cycle and accepts several releases,
// flagging releases of entries that are already free.
module free_index_allocator
  import free_index_allocator_pkg::*;
#(
  parameter int          NUM_ENTRIES = 8,
  parameter int          NUM_RELEASE = 2,
  parameter alloc_mode_e ALLOC_MODE  = ALLOC_FIXED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  free_index_allocator_if.master bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  logic [NUM_ENTRIES-1:0] r_free_bitmap;
  logic [CNT_W-1:0]       r_free_count;
  logic [IDX_W-1:0]       r_last_ptr;
  logic                   r_double_free_err;

  logic [2*NUM_ENTRIES-1:0] w_doubled;
  logic [NUM_ENTRIES-1:0]   w_rotated;
  logic [NUM_ENTRIES-1:0]   w_search;
  logic                     w_found;
  logic [IDX_W-1:0]         w_sel_index;
  logic                     w_grant;
  logic [NUM_ENTRIES-1:0]   w_rel_mask;
  logic [NUM_ENTRIES-1:0]   w_set_mask;
  logic [NUM_ENTRIES-1:0]   w_clear_mask;
  logic [CNT_W-1:0]         w_set_cnt;
  logic                     w_dbl;

  // Rotating by last_ptr puts entry (last_ptr-1) on the MSB, so the highest-bit search
  // walks downward from there with wrap; adding last_ptr back undoes the rotation.
  assign w_doubled = {r_free_bitmap, r_free_bitmap};
  assign w_rotated = NUM_ENTRIES'(w_doubled >> r_last_ptr);
  assign w_search  = (ALLOC_MODE == ALLOC_RR) ? w_rotated : r_free_bitmap;

  next_free_index_comb #(.WIDTH(NUM_ENTRIES)) u_next_free (
    .i_bitmap (w_search),
    .o_found  (w_found),
    .o_index  (w_sel_index)
  );

  assign bus.alloc_valid     = w_found;
  assign bus.alloc_index     = (ALLOC_MODE == ALLOC_RR) ? w_sel_index + r_last_ptr : w_sel_index;
  assign bus.free_bitmap     = r_free_bitmap;
  assign bus.free_count      = r_free_count;
  assign bus.all_free        = (r_free_count == CNT_W'(NUM_ENTRIES));
  assign bus.double_free_err = r_double_free_err;

  assign w_grant      = bus.alloc_valid & bus.alloc_ready;
  assign w_clear_mask = w_grant ? (NUM_ENTRIES'(1) << bus.alloc_index) : '0;

  always_comb begin
    w_rel_mask = '0;
    w_dbl      = 1'b0;
    w_set_cnt  = '0;
    for (int p = 0; p < NUM_RELEASE; p++) begin
      if (bus.release_valid[p]) begin
        // Already free, or already returned by a lower port this cycle.
        if (r_free_bitmap[bus.release_index[p]] | w_rel_mask[bus.release_index[p]]) w_dbl = 1'b1;
        w_rel_mask[bus.release_index[p]] = 1'b1;
      end
    end
    w_set_mask = w_rel_mask & ~r_free_bitmap;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_set_cnt = w_set_cnt + CNT_W'(w_set_mask[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous reset
  // so a mid-cycle reset wins over any grant or release of that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free_bitmap     <= '1;
      r_free_count      <= CNT_W'(NUM_ENTRIES);
      r_last_ptr        <= '0;
      r_double_free_err <= 1'b0;
    end else begin
      r_free_bitmap     <= (r_free_bitmap & ~w_clear_mask) | w_set_mask;
      r_free_count      <= r_free_count - CNT_W'(w_grant) + w_set_cnt;
      r_double_free_err <= w_dbl;
      if (w_grant) r_last_ptr <= bus.alloc_index;
    end
  end

endmodule
